// File: rtl/noc_pkg.sv
// Shared NoC types and packet field positions.
package noc_pkg;
   localparam int PKT_W   = 9;
   localparam int ADDR_HI = 8;
   localparam int ADDR_LO = 5;

   typedef logic [PKT_W-1:0] pkt_t;
   typedef logic             src_t;
endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin grant. prio names the input that wins a tie.
module rr_arb2
   import noc_pkg::*;
(
   input  logic [1:0] valid,
   input  logic       prio,
   input  logic       load,
   output logic [1:0] gnt,
   output src_t       winner
);

   // grant only when the output side can take a packet; ties go to prio
   always_comb begin
      gnt    = 2'b00;
      winner = 1'b0;
      if (load) begin
         gnt[0] = valid[0] && !(valid[1] && prio);
         gnt[1] = valid[1] && !(valid[0] && !prio);
      end
      winner = gnt[1];
   end

endmodule

// File: rtl/noc_merge2.sv
// Two-input merge stage: round-robin arbitration into independent packet (OUT)
// and source-tag (SRC) output registers. A grant requires both slots free so
// the k-th packet and the k-th tag always pair up.
module noc_merge2
   import noc_pkg::*;
#(
   parameter int W = PKT_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in0_valid,
   output logic         in0_ready,
   input  logic [W-1:0] in0_data,
   input  logic         in1_valid,
   output logic         in1_ready,
   input  logic [W-1:0] in1_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic         src_valid,
   input  logic         src_ready,
   output src_t         src_data
);

   logic         out_full_q, out_full_d;
   logic         src_full_q, src_full_d;
   logic [W-1:0] out_data_q, out_data_d;
   src_t         src_data_q, src_data_d;
   logic         prio_q, prio_d;

   logic         out_free, src_free, load, grant;
   logic [1:0]   gnt;
   src_t         winner;

   // slot availability and input readies; readies never look at their own valid
   always_comb begin
      out_free  = !out_full_q || out_ready;
      src_free  = !src_full_q || src_ready;
      load      = out_free && src_free;
      in0_ready = load && !(in1_valid && prio_q);
      in1_ready = load && !(in0_valid && !prio_q);
   end

   rr_arb2 u_arb (
      .valid  ({in1_valid, in0_valid}),
      .prio   (prio_q),
      .load   (load),
      .gnt    (gnt),
      .winner (winner)
   );

   // next state: reload on grant, otherwise drain each slot on its own ready
   always_comb begin
      grant      = |gnt;
      out_full_d = out_full_q;
      src_full_d = src_full_q;
      out_data_d = out_data_q;
      src_data_d = src_data_q;
      prio_d     = prio_q;
      if (out_full_q && out_ready) out_full_d = 1'b0;
      if (src_full_q && src_ready) src_full_d = 1'b0;
      if (grant) begin
         out_full_d = 1'b1;
         src_full_d = 1'b1;
         out_data_d = winner ? in1_data : in0_data;
         src_data_d = winner;
         prio_d     = !winner;
      end
   end

   // state registers; reset clears held packet/tag and the priority pointer
   always_ff @(posedge clk) begin
      if (reset) begin
         out_full_q <= 1'b0;
         src_full_q <= 1'b0;
         out_data_q <= '0;
         src_data_q <= 1'b0;
         prio_q     <= 1'b0;
      end else begin
         out_full_q <= out_full_d;
         src_full_q <= src_full_d;
         out_data_q <= out_data_d;
         src_data_q <= src_data_d;
         prio_q     <= prio_d;
      end
   end

   assign out_valid = out_full_q;
   assign out_data  = out_data_q;
   assign src_valid = src_full_q;
   assign src_data  = src_data_q;

endmodule

// File: tb/tb_noc_merge2.sv
// Directed and randomized bench for noc_merge2 with a queue-based reference.
module tb_noc_merge2;

   logic       clk, reset;
   logic       in0_valid, in0_ready, in1_valid, in1_ready;
   logic [8:0] in0_data, in1_data, out_data;
   logic       out_valid, out_ready, src_valid, src_ready, src_data;

   int checks = 0;
   int failures = 0;

   logic [8:0] oq[$];
   logic       sq[$];
   logic       mprio;
   int         wait0, wait1, accepted, drained;
   logic       hold0, hold1;

   noc_merge2 #(.W(9)) dut (
      .clk       (clk),
      .reset     (reset),
      .in0_valid (in0_valid),
      .in0_ready (in0_ready),
      .in0_data  (in0_data),
      .in1_valid (in1_valid),
      .in1_ready (in1_ready),
      .in1_data  (in1_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .src_valid (src_valid),
      .src_ready (src_ready),
      .src_data  (src_data)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // one cycle of random (or idle) stimulus checked against the queue model
   task automatic model_cycle(input bit gen);
      bit ld, er0, er1, hs0, hs1;
      if (gen) begin
         if (!hold0) begin
            in0_valid = ($urandom_range(0, 99) < 60);
            in0_data  = 9'($urandom);
         end
         if (!hold1) begin
            in1_valid = ($urandom_range(0, 99) < 60);
            in1_data  = 9'($urandom);
         end
         out_ready = ($urandom_range(0, 99) < 75);
         src_ready = ($urandom_range(0, 99) < 75);
      end else begin
         in0_valid = 1'b0;
         in1_valid = 1'b0;
         out_ready = 1'b1;
         src_ready = 1'b1;
      end
      #1;
      chk("rnd_out_valid", out_valid, oq.size() != 0);
      if (oq.size() != 0) chk("rnd_out_data", out_data, oq[0]);
      chk("rnd_src_valid", src_valid, sq.size() != 0);
      if (sq.size() != 0) chk("rnd_src_data", src_data, sq[0]);
      ld  = (oq.size() == 0 || out_ready) && (sq.size() == 0 || src_ready);
      er0 = ld && !(in1_valid && mprio);
      er1 = ld && !(in0_valid && !mprio);
      chk("rnd_in0_ready", in0_ready, er0);
      chk("rnd_in1_ready", in1_ready, er1);
      hs0 = in0_valid && in0_ready;
      hs1 = in1_valid && in1_ready;
      chk("rnd_single_grant", hs0 && hs1, 0);
      if (oq.size() != 0 && out_ready) begin
         void'(oq.pop_front());
         drained++;
      end
      if (sq.size() != 0 && src_ready) void'(sq.pop_front());
      if (hs0 || hs1) begin
         oq.push_back(hs1 ? in1_data : in0_data);
         sq.push_back(hs1);
         accepted++;
         mprio = !hs1;
         if (hs1) begin
            wait1 = 0;
            if (in0_valid) begin
               wait0++;
               chk("rnd_fair_in0", wait0 <= 1, 1);
            end
         end else begin
            wait0 = 0;
            if (in1_valid) begin
               wait1++;
               chk("rnd_fair_in1", wait1 <= 1, 1);
            end
         end
      end
      if (!in0_valid) wait0 = 0;
      if (!in1_valid) wait1 = 0;
      hold0 = in0_valid && !hs0;
      hold1 = in1_valid && !hs1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset     = 1'b1;
      in0_valid = 1'b0;
      in1_valid = 1'b0;
      in0_data  = '0;
      in1_data  = '0;
      out_ready = 1'b1;
      src_ready = 1'b1;
      tick();
      tick();
      reset = 1'b0;

      // reset state
      chk("rst_out_valid", out_valid, 0);
      chk("rst_src_valid", src_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_src_data", src_data, 0);
      #1;
      chk("rst_in0_ready", in0_ready, 1);
      chk("rst_in1_ready", in1_ready, 1);

      // single packet from in0
      in0_valid = 1'b1;
      in0_data  = 9'h1A3;
      #1;
      chk("t1_in0_ready", in0_ready, 1);
      tick();
      in0_valid = 1'b0;
      chk("t1_out_valid", out_valid, 1);
      chk("t1_out_data", out_data, 9'h1A3);
      chk("t1_src_data", src_data, 0);
      // prio is now 1: on contention in1 gets the ready
      in0_valid = 1'b1;
      in1_valid = 1'b1;
      #1;
      chk("t1_prio_in0_ready", in0_ready, 0);
      chk("t1_prio_in1_ready", in1_ready, 1);
      in0_valid = 1'b0;
      in1_valid = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;

      // continuous contention alternates 0,1,0,1
      for (int k = 0; k < 8; k++) begin
         in0_valid = 1'b1;
         in1_valid = 1'b1;
         in0_data  = 9'h100 + 9'(k / 2);
         in1_data  = 9'h0F0 + 9'(k / 2);
         #1;
         chk("t2_in0_ready", in0_ready, (k % 2) == 0);
         chk("t2_in1_ready", in1_ready, (k % 2) == 1);
         tick();
         chk("t2_out_valid", out_valid, 1);
         chk("t2_out_data", out_data, (k % 2) ? 9'h0F0 + 9'(k / 2) : 9'h100 + 9'(k / 2));
         chk("t2_src_data", src_data, k % 2);
      end
      in0_valid = 1'b0;
      in1_valid = 1'b0;

      // out_ready low for 3 cycles: packet held, no input transfer
      out_ready = 1'b0;
      in0_valid = 1'b1;
      in0_data  = 9'h155;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("t3_in0_ready", in0_ready, 0);
         chk("t3_in1_ready", in1_ready, 0);
         chk("t3_out_valid", out_valid, 1);
         chk("t3_out_data", out_data, 9'h0F3);
         tick();
      end
      out_ready = 1'b1;
      #1;
      chk("t3_release_ready", in0_ready, 1);
      tick();
      in0_valid = 1'b0;
      chk("t3_out_data_new", out_data, 9'h155);
      chk("t3_src_data_new", src_data, 0);

      // SRC stalled while OUT drains: no grant until src_ready returns
      src_ready = 1'b0;
      in1_valid = 1'b1;
      in1_data  = 9'h0AA;
      #1;
      chk("t4_in1_ready_a", in1_ready, 0);
      tick();
      chk("t4_out_valid", out_valid, 0);
      chk("t4_src_valid", src_valid, 1);
      chk("t4_src_held", src_data, 0);
      #1;
      chk("t4_in1_ready_b", in1_ready, 0);
      tick();
      chk("t4_out_valid_b", out_valid, 0);
      src_ready = 1'b1;
      #1;
      chk("t4_in1_ready_c", in1_ready, 1);
      tick();
      in1_valid = 1'b0;
      chk("t4_out_valid_c", out_valid, 1);
      chk("t4_out_data", out_data, 9'h0AA);
      chk("t4_src_data", src_data, 1);

      // reset mid-operation with in1 handshaking
      in0_valid = 1'b1;
      in0_data  = 9'h011;
      tick();
      in0_valid = 1'b0;
      in1_valid = 1'b1;
      in1_data  = 9'h077;
      reset     = 1'b1;
      #1;
      chk("t5_in1_ready", in1_ready, 1);
      tick();
      reset     = 1'b0;
      in1_valid = 1'b0;
      chk("t5_out_valid", out_valid, 0);
      chk("t5_src_valid", src_valid, 0);
      chk("t5_out_data", out_data, 0);
      tick();
      chk("t5_out_valid_b", out_valid, 0);
      in0_valid = 1'b1;
      in1_valid = 1'b1;
      #1;
      chk("t5_prio_in0", in0_ready, 1);
      chk("t5_prio_in1", in1_ready, 0);
      in0_valid = 1'b0;
      in1_valid = 1'b0;
      tick();

      // randomized traffic against the queue model
      mprio    = 1'b0;
      wait0    = 0;
      wait1    = 0;
      accepted = 0;
      drained  = 0;
      hold0    = 1'b0;
      hold1    = 1'b0;
      for (int c = 0; c < 10000; c++) model_cycle(1'b1);
      for (int c = 0; c < 4; c++) model_cycle(1'b0);
      chk("end_queue_empty", oq.size(), 0);
      chk("end_all_delivered", drained, accepted);
      chk("end_traffic_seen", accepted > 1000, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/noc_merge2.md
# noc_merge2

Two-input, one-output merge stage of the synchronous NoC router. It sits directly downstream of the `decoder2` routing stage: each output port of a router node is fed by the matching `Out0`/`Out1` branch of two decoders. The block arbitrates fairly between the two requesters and registers the winning 9-bit packet, plus a 1-bit source tag, into two independent output channels.

## Interface
- `W`, default 9: packet width; bits [8:5] are the address, bits [4:0] are the payload.
- `clk`, input, 1: single clock; every state element updates on the rising edge.
- `reset`, input, 1: synchronous reset, active-high.
- `in0_valid`, input, 1: packet offered on input 0.
- `in0_ready`, output, 1: input 0 accepts this cycle.
- `in0_data`, input, W: packet on input 0.
- `in1_valid`, `in1_ready`, `in1_data`: same as input 0, for input 1.
- `out_valid`, output, 1: registered packet available.
- `out_ready`, input, 1: downstream accepts the packet.
- `out_data`, output, W: registered packet.
- `src_valid`, output, 1: registered source tag available.
- `src_ready`, input, 1: consumer accepts the tag.
- `src_data`, output, 1: index of the input that supplied the matching packet.

## Operation
- Handshakes are valid/ready. A transfer happens on a rising edge where both valid and ready are high.
  - Upstream must hold data stable while valid is high and ready is low.
  - This block holds `out_data` and `src_data` stable under the same rule.
- The block has two output registers, OUT and SRC, each with its own full flag.
  - A slot is free this cycle if it is empty, or if it is full and its ready is high.
  - `load = out_free && src_free`. A grant happens only when `load` is true.
- Round-robin pointer `prio` (1 bit) names the input that has priority on a tie.
  - Reset value: 0.
  - Both inputs valid: the winner is `prio`.
  - One input valid: that input wins.
- Ready equations:
  - `in0_ready = load && !(in1_valid && prio==1)`.
  - `in1_ready = load && !(in0_valid && prio==0)`.
  - Neither ready depends on its own valid.
- On a grant:
  - OUT is loaded with the winner's data and SRC with the winner's index; both become full.
  - `prio` is set to the inverse of the winner, whether or not there was contention.
- Without a grant, `prio` holds. A full slot whose ready is high and that is not reloaded becomes empty.
- The two output channels drain independently. A new grant waits until both are free, so the k-th packet and the k-th tag always pair up.
- Packet bits pass through unmodified. No field of the packet is examined.

## Timing
- Reset values: `out_valid=0`, `src_valid=0`, `out_data=0`, `src_data=0`, `prio=0`.
  - `in0_ready` and `in1_ready` are high in the first cycle after reset.
- Reset asserted mid-operation discards any held packet and tag on that edge. An input handshake in the same cycle is not a transfer; the packet is lost.
- Latency: an input accepted at edge N appears on `out_valid`/`src_valid` after edge N.
- Throughput: one packet per cycle while `out_ready` and `src_ready` stay high.
  - Under continuous contention, grants alternate 0,1,0,1.
- Stall cases:
  - OUT full with `out_ready` low: no grant; both input readies are low.
  - OUT draining while SRC is stalled: no grant, because a grant needs both slots free.
- Simultaneous drain and load in one cycle: the slot stays full with the new contents, with no bubble.
- No combinational path from `in*_valid` or `in*_data` to `out_*` or `src_*`.
- Combinational paths from `out_ready` and `src_ready` to `in*_ready` are permitted.

## Structure
- Shared package `noc_pkg` holds:
  - `PKT_W=9`, `ADDR_HI=8`, `ADDR_LO=5`.
  - The `pkt_t` typedef (a `logic [8:0]`).
  - `src_t` (a 1-bit `logic`).
- One sub-module, `rr_arb2`: combinational two-way round-robin grant from `valid[1:0]`, `prio` and `load`. It outputs `gnt[1:0]` and `winner`.
- The `prio` flop, the output registers and the full flags live in `noc_merge2`.

## Test plan
- Reset, then `in0_valid=1` with `in0_data=9'h1A3`, both output readies high → `in0_ready=1` in the cycle after reset; next cycle `out_data=9'h1A3`, `src_data=0`; `prio` becomes 1.
- Both inputs valid every cycle, in0 carrying 9'h100..9'h103 and in1 carrying 9'h0F0..9'h0F3, readies high → output order 100,0F0,101,0F1,…; `src_data` sequence 0,1,0,1…; one packet per cycle.
- `out_ready=0` for 3 cycles with one packet held → `out_data` is stable for all 3 cycles, both input readies are low, and no input transfer occurs.
- `src_ready=0` while `out_ready=1` → OUT drains and `out_valid` drops, SRC stays full, and no new grant occurs. Then raise `src_ready` → the next packet is granted on that edge.
- `reset` asserted for one cycle while OUT/SRC are full and `in1` is handshaking → after the edge `out_valid=0` and `src_valid=0`, the in1 packet never appears, and `prio=0`.
- Random valid/ready stimulus for 10k cycles with a scoreboard → every accepted packet appears exactly once, in grant order, paired with the correct `src_data`, and neither input waits more than 1 grant while requesting.
